mips_cpu_instr_loader: RTL and testbench
========================================

MIPS_CPU_INSTR_LOADER -- requirements
Module: mips_cpu_instr_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, instruction words held (power of two, 4..1024).
REQ-002 Parameter BASE_ADDR, default 32'hBFC00000, byte address of word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  load word offered.
REQ-006 load_ready  output  1  loader accepts word this cycle.
REQ-007 load_data  input  32  instruction word, logical (MSB = opcode) order.
REQ-008 load_last  input  1  qualifies final word of program.
REQ-009 reload  input  1  single-cycle request to reprogram.
REQ-010 cpu_reset  output  1  active-high reset driven to mips_cpu_harvard reset.
REQ-011 loaded  output  1  program present, CPU running.
REQ-012 load_overflow  output  1  sticky: DEPTH_WORDS words accepted without load_last.
REQ-013 instr_address  input  32  CPU fetch byte address.
REQ-014 instr_readdata  output  32  fetched word, byte-swapped to CPU big-endian lane order {[7:0],[15:8],[23:16],[31:24]}.
REQ-015 addr_fault  output  1  fetch outside the window or misaligned (see Configuration).

Function
REQ-016 FSM states LOAD, RELEASE, RUN; reset enters LOAD.
REQ-017 LOAD: load_ready=1; handshake = load_valid & load_ready; each handshake writes load_data to mem[wptr], wptr+1.
REQ-018 Handshake with load_last=1 -> RELEASE next cycle; wptr not used further.
REQ-019 Handshake at wptr=DEPTH_WORDS-1 with load_last=0 -> treated as last; load_overflow set; -> RELEASE.
REQ-020 RELEASE lasts exactly 1 cycle, cpu_reset=1, load_ready=0; -> RUN.
REQ-021 RUN: cpu_reset=0, loaded=1, load_ready=0; load_valid ignored, memory unchanged.
REQ-022 reload=1 in RUN -> LOAD next cycle: wptr=0, cpu_reset=1, loaded=0, all words cleared to 0, load_overflow cleared.
REQ-023 reload in LOAD or RELEASE ignored; reload and load_valid in same RUN cycle: reload wins, word dropped.
REQ-024 cpu_reset=1 in LOAD and RELEASE; first RUN cycle is first cycle with cpu_reset=0.
REQ-025 Fetch read combinational: index = (instr_address-BASE_ADDR)>>2, no added latency.
REQ-026 Unwritten words read 32'h00000000 (NOP).
REQ-027 instr_address=0 (CPU halt address) -> instr_readdata=0, addr_fault=0.
REQ-028 Other addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) -> instr_readdata=0.
REQ-029 Fetch during LOAD returns current memory contents; CPU is held in reset, so no effect.

Reset
REQ-030 reset_n=0 asynchronously: state=LOAD, wptr=0, all words 0, cpu_reset=1, loaded=0, load_overflow=0, load_ready=1 on first cycle after release.
REQ-031 reset_n asserted mid-load or mid-run discards the program; reload required from word 0.

Configuration
REQ-032 Macro INSTR_LOADER_FAULT_EN.
REQ-033 Defined: addr_fault=1 combinationally for out-of-window address (excluding 0) or instr_address[1:0]!=0; misaligned fetch returns 0.
REQ-034 Undefined: addr_fault tied 0; instr_address[1:0] ignored (word index only); out-of-window still returns 0.

Verification
REQ-035 Reset, load 0x0FF00003,0x24420020,0x24420001,0x00000008(last) -> cpu_reset falls 2 cycles after last handshake; fetch 0xBFC00000 gives 0x03 00 F0 0F.
REQ-036 load_valid held 1, load_last never, DEPTH_WORDS=64 -> 64 handshakes, load_overflow=1, RUN entered, load_ready=0.
REQ-037 Fetch 0xBFC00010 after 4-word load -> 0x00000000; fetch 0x00000000 -> 0, addr_fault=0.
REQ-038 With INSTR_LOADER_FAULT_EN: fetch 0xBFC00002 -> addr_fault=1, data 0; fetch 0x80000000 -> addr_fault=1; without macro both addr_fault=0.
REQ-039 reload pulse in RUN with load_valid=1 same cycle -> LOAD, cpu_reset=1, word dropped, fetch 0xBFC00000 reads 0.
REQ-040 reset_n low after 2 of 4 load words -> immediate cpu_reset=1, memory 0; restarted load of 4 words completes normally.

Source files
------------

// File: rtl/mips_cpu_instr_loader.sv
// Instruction loader: streams a program into a word memory, then releases the CPU from reset.
// Define INSTR_LOADER_FAULT_EN to report misaligned and out-of-window fetches on addr_fault.
module mips_cpu_instr_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        reload,
    output logic        cpu_reset,
    output logic        loaded,
    output logic        load_overflow,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        addr_fault
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {StLoad, StRelease, StRun} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [DEPTH_WORDS-1:0] valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic [31:0]            mem_q [DEPTH_WORDS];
    logic                   handshake;

    assign handshake = load_valid && (state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
        loaded     = 1'b0;
        unique case (state_q)
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    valid_d[wptr_q] = 1'b1;
                    wptr_d          = wptr_q + AW'(1);
                    if (load_last || wptr_q == LastIdx) begin
                        state_d = StRelease;
                    end
                    // Memory full without a last marker: close the program anyway.
                    if (!load_last && wptr_q == LastIdx) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StRelease: begin
                state_d = StRun;
            end
            StRun: begin
                cpu_reset = 1'b0;
                loaded    = 1'b1;
                if (reload) begin
                    state_d = StLoad;
                    wptr_d  = '0;
                    valid_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StLoad;
            wptr_q  <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Contents need no reset: per-word valid bits make unwritten words read as zero.
    always_ff @(posedge clk) begin
        if (handshake) begin
            mem_q[wptr_q] <= load_data;
        end
    end

    assign load_overflow = ovf_q;

    logic [29:0]   word_off;
    logic [AW-1:0] rd_idx;
    logic          in_window;
    logic [31:0]   rd_word;
    logic [31:0]   rd_swapped;

    assign word_off   = instr_address[31:2] - BASE_ADDR[31:2];
    assign rd_idx     = word_off[AW-1:0];
    assign in_window  = (word_off[29:AW] == '0);
    assign rd_word    = valid_q[rd_idx] ? mem_q[rd_idx] : 32'h0;
    assign rd_swapped = {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]};

`ifdef INSTR_LOADER_FAULT_EN
    logic misaligned;

    assign misaligned     = (instr_address[1:0] != 2'b00);
    assign addr_fault     = misaligned || (!in_window && (instr_address != 32'h0));
    assign instr_readdata = (in_window && !misaligned) ? rd_swapped : 32'h0;
`else
    logic [1:0] unused_addr_lsbs;

    assign unused_addr_lsbs = instr_address[1:0];
    assign addr_fault       = 1'b0;
    assign instr_readdata   = in_window ? rd_swapped : 32'h0;
`endif

endmodule

// File: tb/tb_mips_cpu_instr_loader.sv
// Self-checking bench for mips_cpu_instr_loader: directed scenarios plus randomized traffic
// compared every cycle against a program-level model.
module tb_mips_cpu_instr_loader;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = 32'h0;
    logic        load_last = 1'b0;
    logic        reload = 1'b0;
    logic        cpu_reset;
    logic        loaded;
    logic        load_overflow;
    logic [31:0] instr_address = 32'h0;
    logic [31:0] instr_readdata;
    logic        addr_fault;

    mips_cpu_instr_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .reload        (reload),
        .cpu_reset     (cpu_reset),
        .loaded        (loaded),
        .load_overflow (load_overflow),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .addr_fault    (addr_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Program-level model: a list of stored words and where the CPU is in its life cycle.
    logic [31:0] m_words [DEPTH];
    int          m_count;
    bit          m_release;
    bit          m_running;
    bit          m_ovf;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_words[i] = 32'h0;
        m_count   = 0;
        m_release = 1'b0;
        m_running = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
        end else if (m_running) begin
            if (reload) model_reset();
        end else if (m_release) begin
            m_release = 1'b0;
            m_running = 1'b1;
        end else if (load_valid) begin
            m_words[m_count] = load_data;
            m_count++;
            if (load_last) begin
                m_release = 1'b1;
            end else if (m_count == DEPTH) begin
                m_release = 1'b1;
                m_ovf     = 1'b1;
            end
        end
    endtask

    function automatic bit in_win(logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic logic [31:0] exp_data(logic [31:0] a);
        logic [31:0] w;
        if (!in_win(a)) return 32'h0;
`ifdef INSTR_LOADER_FAULT_EN
        if (a % 4 != 0) return 32'h0;
`endif
        w = m_words[(a - BASE) / 4];
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic exp_fault(logic [31:0] a);
`ifdef INSTR_LOADER_FAULT_EN
        return (a % 4 != 0) || (!in_win(a) && a != 32'h0);
`else
        return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("load_ready", 32'(load_ready), 32'(!m_running && !m_release));
            chk("cpu_reset", 32'(cpu_reset), 32'(!m_running));
            chk("loaded", 32'(loaded), 32'(m_running));
            chk("load_overflow", 32'(load_overflow), 32'(m_ovf));
            chk("instr_readdata", instr_readdata, exp_data(instr_address));
            chk("addr_fault", 32'(addr_fault), 32'(exp_fault(instr_address)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        load_valid = 1'b0;
        load_last  = 1'b0;
        reload     = 1'b0;
    endtask

    task automatic fetch(logic [31:0] a);
        instr_address = a;
        #1;
    endtask

    task automatic load_prog(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
        logic [31:0] p [4];
        p = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = p[i];
            load_last  = (i == 3);
            cyc();
        end
        set_idle();
    endtask

    int last_mod;

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #2 cmp_en = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;

        // Reset state
        fetch(BASE);
        chk("rst load_ready", 32'(load_ready), 32'd1);
        chk("rst cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst loaded", 32'(loaded), 32'd0);
        chk("rst overflow", 32'(load_overflow), 32'd0);
        chk("rst fetch", instr_readdata, 32'h0);

        // Four-word program; one RELEASE cycle then RUN
        load_prog(32'h0FF00003, 32'h24420020, 32'h24420001, 32'h00000008);
        #1;
        chk("release cpu_reset", 32'(cpu_reset), 32'd1);
        chk("release load_ready", 32'(load_ready), 32'd0);
        cyc();
        chk("run cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run loaded", 32'(loaded), 32'd1);
        fetch(BASE);
        chk("fetch word0", instr_readdata, 32'h0300F00F);
        fetch(BASE + 32'd4);
        chk("fetch word1", instr_readdata, 32'h20004224);
        fetch(BASE + 32'h10);
        chk("fetch unwritten", instr_readdata, 32'h0);
        fetch(32'h0);
        chk("fetch halt data", instr_readdata, 32'h0);
        chk("fetch halt fault", 32'(addr_fault), 32'd0);
        fetch(BASE + 32'd2);
`ifdef INSTR_LOADER_FAULT_EN
        chk("misaligned fault", 32'(addr_fault), 32'd1);
        chk("misaligned data", instr_readdata, 32'h0);
`else
        chk("misaligned fault", 32'(addr_fault), 32'd0);
        chk("misaligned data", instr_readdata, 32'h0300F00F);
`endif
        fetch(32'h80000000);
        chk("outside data", instr_readdata, 32'h0);
`ifdef INSTR_LOADER_FAULT_EN
        chk("outside fault", 32'(addr_fault), 32'd1);
`else
        chk("outside fault", 32'(addr_fault), 32'd0);
`endif

        // Reload wins over a simultaneous load word
        reload     = 1'b1;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'hDEADBEEF;
        cyc();
        set_idle();
        fetch(BASE);
        chk("reload cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload loaded", 32'(loaded), 32'd0);
        chk("reload load_ready", 32'(load_ready), 32'd1);
        chk("reload cleared", instr_readdata, 32'h0);

        // Overflow: DEPTH words without load_last
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = 32'(i + 1);
            cyc();
            if (i == DEPTH - 2) chk("ovf ready before full", 32'(load_ready), 32'd1);
        end
        set_idle();
        #1;
        chk("ovf flag", 32'(load_overflow), 32'd1);
        chk("ovf load_ready", 32'(load_ready), 32'd0);
        cyc();
        chk("ovf running", 32'(loaded), 32'd1);
        fetch(BASE + 32'(4 * (DEPTH - 1)));
        chk("ovf last word", instr_readdata, 32'h40000000);
        fetch(BASE + 32'(4 * DEPTH));
        chk("past window", instr_readdata, 32'h0);

        // Reset after two of four words, then a clean restart
        reload = 1'b1;
        cyc();
        set_idle();
        chk("reload clears ovf", 32'(load_overflow), 32'd0);
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h11223344 + 32'(i);
            cyc();
        end
        set_idle();
        fetch(BASE);
        chk("partial word0", instr_readdata, 32'h44332211);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midload reset data", instr_readdata, 32'h0);
        chk("midload reset cpu_reset", 32'(cpu_reset), 32'd1);
        cyc();
        reset_n = 1'b1;
        load_prog(32'h0FF00003, 32'h24420020, 32'h24420001, 32'h00000008);
        cyc();
        fetch(BASE + 32'd12);
        chk("restart running", 32'(loaded), 32'd1);
        chk("restart word3", instr_readdata, 32'h08000000);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrun reset cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrun reset loaded", 32'(loaded), 32'd0);
        cyc();
        reset_n = 1'b1;

        // Randomized traffic
        last_mod = 3;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom_range(2))
                    0: last_mod = 3;
                    1: last_mod = 20;
                    default: last_mod = 400;
                endcase
            end
            if ($urandom_range(499) == 0) begin
                reset_n = 1'b0;
                model_reset();
                repeat (2) cyc();
                reset_n = 1'b1;
            end
            load_valid = ($urandom_range(9) < 7);
            load_data  = $urandom;
            load_last  = ($urandom_range(last_mod - 1) == 0);
            reload     = ($urandom_range(29) == 0);
            case ($urandom_range(5))
                0: instr_address = BASE + 32'($urandom_range(DEPTH - 1) * 4);
                1: instr_address = BASE + 32'($urandom_range(7) * 4);
                2: instr_address = BASE + 32'($urandom_range(4 * DEPTH - 1));
                3: instr_address = 32'h0;
                4: instr_address = $urandom_range(1) ? BASE + 32'(4 * DEPTH + $urandom_range(15))
                                                     : BASE - 32'($urandom_range(1, 8));
                default: instr_address = $urandom;
            endcase
            cyc();
        end

        set_idle();
        cyc();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
